// File: rtl/spiker_stream_adapter.sv
// spiker_stream_adapter
//
// Snapshots a word-packed spike vector on start and streams it to the spiking
// core LANES spikes per beat over a valid/ready channel. In parallel it collects
// the core's result beats into a word-aligned result vector. Both channels run
// independently while in RUN. A frame ends once every outbound beat has been
// accepted and every result beat has been collected.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               frame request, honoured only in IDLE
//   spikes_i              input spikes, spike s at bit s (word i at [i*WIDTH +: WIDTH])
//   result_o              collected result spikes, same bit mapping
//   busy_o / done_o       high in RUN / one-cycle pulse at frame completion
//   core_valid_o/_ready_i outbound beat handshake
//   core_data_o           outbound spikes, core_last_o flags the final beat
//   res_valid_i/res_ready_o/res_data_i  inbound result beat handshake and data
module spiker_stream_adapter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_SPIKES = 784,
    parameter int unsigned LANES    = 8,
    localparam int unsigned N_WORDS = (N_SPIKES + WIDTH - 1) / WIDTH,
    localparam int unsigned N_BEATS = (N_SPIKES + LANES - 1) / LANES,
    localparam int unsigned BEAT_W  = $clog2(N_BEATS + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [N_WORDS*WIDTH-1:0] spikes_i,
    output logic [N_WORDS*WIDTH-1:0] result_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     core_valid_o,
    input  logic                     core_ready_i,
    output logic [LANES-1:0]         core_data_o,
    output logic                     core_last_o,
    input  logic                     res_valid_i,
    output logic                     res_ready_o,
    input  logic [LANES-1:0]         res_data_i
);

    localparam int unsigned TOT_W     = N_WORDS * WIDTH;
    localparam int unsigned BEAT_BITS = N_BEATS * LANES;
    // Internal vectors cover both the word-aligned and the beat-aligned extent,
    // so every beat-sized part-select stays in range.
    localparam int unsigned PAD_W     = (BEAT_BITS > TOT_W) ? BEAT_BITS : TOT_W;

    localparam logic [BEAT_W-1:0] BEAT_CNT  = BEAT_W'(N_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [BEAT_W-1:0] tx_q, rx_q;
    logic [BEAT_W-1:0] tx_next, rx_next;
    logic [BEAT_W-1:0] tx_sel, rx_sel;
    logic [31:0]       tx_base, rx_base;
    logic [PAD_W-1:0]  snap_q, res_q;
    logic [PAD_W-1:0]  spike_mask, spikes_pad;
    logic              tx_fire, rx_fire;

    // Ones on real spike positions; padding positions stay zero everywhere.
    always_comb begin
        spike_mask = '0;
        for (int unsigned i = 0; i < N_SPIKES; i++) begin
            spike_mask[i] = 1'b1;
        end
    end

    always_comb begin
        spikes_pad              = '0;
        spikes_pad[TOT_W-1:0]   = spikes_i;
    end

    assign busy_o       = (state_q == StRun);
    assign done_o       = (state_q == StDone);
    assign core_valid_o = (state_q == StRun) && (tx_q < BEAT_CNT);
    assign core_last_o  = core_valid_o && (tx_q == LAST_BEAT);
    assign res_ready_o  = (state_q == StRun) && (rx_q < BEAT_CNT);

    assign tx_fire = core_valid_o & core_ready_i;
    assign rx_fire = res_ready_o & res_valid_i;
    assign tx_next = tx_q + BEAT_W'(tx_fire);
    assign rx_next = rx_q + BEAT_W'(rx_fire);

    // Counters reach N_BEATS at the end of a frame; clamp so the selects never
    // point past the vectors.
    assign tx_sel  = core_valid_o ? tx_q : '0;
    assign rx_sel  = res_ready_o ? rx_q : '0;
    assign tx_base = 32'(tx_sel) * LANES;
    assign rx_base = 32'(rx_sel) * LANES;

    // Snapshot is already masked, so padding lanes of the final beat read as 0.
    assign core_data_o = core_valid_o ? snap_q[tx_base +: LANES] : '0;
    assign result_o    = res_q[TOT_W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            tx_q    <= '0;
            rx_q    <= '0;
            snap_q  <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StRun;
                        snap_q  <= spikes_pad & spike_mask;
                        res_q   <= '0;
                        tx_q    <= '0;
                        rx_q    <= '0;
                    end
                end
                StRun: begin
                    tx_q <= tx_next;
                    rx_q <= rx_next;
                    if (rx_fire) begin
                        res_q[rx_base +: LANES] <= res_data_i & spike_mask[rx_base +: LANES];
                    end
                    if ((tx_next == BEAT_CNT) && (rx_next == BEAT_CNT)) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/spiker_stream_adapter.md
# spiker_stream_adapter

Parametrised successor to the register-file spike unwrapper. It snapshots a WIDTH-bit-word spike vector, streams it to the spiking core LANES spikes per beat over a valid/ready channel, and collects the core's result beats into a word-aligned result vector. It sits between the spiker_adapter register file and the spiking core. A start/busy/done handshake replaces the unwrapper's purely combinational pass-through.

## Interface
- WIDTH, 32, bits per register word
- N_SPIKES, 784, spikes per frame (need not be a multiple of WIDTH or LANES)
- LANES, 8, spikes per stream beat (1..WIDTH)
- Derived: N_WORDS = ceil(N_SPIKES/WIDTH); N_BEATS = ceil(N_SPIKES/LANES); BEAT_W = clog2(N_BEATS+1)

- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  request a frame; honoured only in IDLE
- spikes_i  in  N_WORDS*WIDTH  register words, word i at [i*WIDTH +: WIDTH]; spike s at bit s
- result_o  out  N_WORDS*WIDTH  collected result spikes, same bit mapping
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse at frame completion
- core_valid_o  out  1  outbound beat valid
- core_ready_i  in  1  core accepts beat
- core_data_o  out  LANES  outbound spikes
- core_last_o  out  1  marks beat N_BEATS-1
- res_valid_i  in  1  result beat valid
- res_ready_o  out  1  adapter accepts result beat
- res_data_i  in  LANES  result spikes

## Operation
- FSM with states IDLE, RUN and DONE.
  - IDLE → RUN on start_i. At that edge: latch spikes_i into the snapshot, clear tx_cnt and rx_cnt, and clear result_o to 0.
  - RUN → DONE on the edge where tx_cnt and rx_cnt both equal N_BEATS (counted after this cycle's handshakes).
  - DONE → IDLE unconditionally.
- start_i is ignored in RUN and DONE.
- Outbound channel:
  - core_valid_o = (state==RUN && tx_cnt<N_BEATS).
  - core_data_o = snap[tx_cnt*LANES +: LANES]. Bit positions ≥ N_SPIKES are forced to 0.
  - core_last_o = core_valid_o && tx_cnt==N_BEATS-1.
  - tx_cnt increments on core_valid_o && core_ready_i.
- Result channel:
  - res_ready_o = (state==RUN && rx_cnt<N_BEATS).
  - On res_valid_i && res_ready_o: write res_data_i into result_o[rx_cnt*LANES +: LANES], discard positions ≥ N_SPIKES, then increment rx_cnt.
- The two channels are independent. Results may arrive before, during or after the corresponding outbound beats, and both handshakes may complete in the same cycle. Result beats offered outside RUN, or after N_BEATS are collected, are not accepted.
- Bits of result_o at positions ≥ N_SPIKES are always 0.
- result_o holds its value from DONE until the next accepted start.
- spikes_i changes after the start edge have no effect on the frame.
- Reset, asynchronous at any time including mid-frame: state=IDLE, counters=0, snapshot=0, result_o=0, busy_o=0, done_o=0, core_valid_o=0, core_last_o=0, res_ready_o=0, core_data_o=0. No partial frame resumes after reset.

## Timing
- start_i is sampled at edge T. busy_o and core_valid_o rise in cycle T+1, with beat 0 presented.
- An outbound beat is held stable, data and last included, until it is accepted. There are no bubbles while core_ready_i stays high.
- Minimum frame: core_ready_i=1 and a result beat every cycle from T+1. RUN lasts N_BEATS cycles, done_o pulses in cycle T+1+N_BEATS, and the FSM is back in IDLE at T+2+N_BEATS.
- done_o and busy_o are never high together.
- Earliest next start is sampled in the first IDLE cycle.
- All outputs are registered or decoded from registered state and counters. There is no combinational path from any input to any output.

## Test plan
- Default parameters, all-ones spikes_i, core_ready_i=1, results echoed the same cycle:
  - 98 beats; beat 97 has core_last_o=1 and data 8'hFF.
  - done_o pulses at T+99.
  - result_o bits 0..783 are 1 and bits 784..799 are 0.
- N_SPIKES=20, WIDTH=8, LANES=8, spikes_i=24'hFF_A5_3C:
  - beats 8'h3C, 8'hA5, 8'h0F (padding masked); last beat flagged.
  - Returning 8'hFF on all three beats gives result_o=24'h0F_FF_FF.
- Random core_ready_i and res_valid_i stalls, including result beats arriving before outbound beats:
  - core_data_o is stable while stalled.
  - result_o matches the expected bit-reverse pattern.
  - done_o fires exactly once.
- start_i pulsed during RUN and DONE, and spikes_i changed mid-frame: no restart, and the outbound data equals the snapshot.
- rst_i asserted at beat 40:
  - All outputs go to 0 immediately.
  - A subsequent start runs a full clean frame from beat 0.
- res_valid_i held high in IDLE and after N_BEATS results: res_ready_o=0 and result_o unchanged.
